ss_scan_controller: RTL and testbench
=====================================

# ss_scan_controller

Time-multiplexed scan controller for the four-digit seven-segment display of the wall clock. It shares the single segment bus between four digits and snapshots the BCD time digits at each frame boundary so a frame never shows a torn value. It applies per-frame PWM brightness and inserts a blanking guard between digits to prevent ghosting. It sits between the timekeeping logic (hours/minutes registers, PWM brightness setting) and the board's anode/cathode pins.

## Interface
- TICK_DIV, 6250: clock cycles per PWM sub-tick; ≥1.
- BLANK_CYCLES, 200: guard cycles with everything off before each digit slot; ≥1.
- CLK100MHZ  in  1  system clock, 100 MHz.
- Reset  in  1  asynchronous, active-high reset.
- digit3, digit2, digit1, digit0  in  4 each  BCD digits; digit3 is the leftmost (hours tens), digit0 is the rightmost (minutes units).
- dp_mask  in  4  decimal point enable per digit; bit i maps to digit i; 1 = lit.
- brightness  in  4  PWM level; 0 = 1/16 duty, 15 = 16/16 duty.
- display_en  in  1  0 forces the display dark; the scan timing keeps running.
- SegmentDrivers  out  4  anode enables, active-low; bit i selects digit i.
- SevenSegment  out  8  cathodes, active-low; bit order is {dp,g,f,e,d,c,b,a}.
- frame_start  out  1  one-cycle pulse when the inputs are snapshotted.

## Operation
- Slot structure:
  - Each digit slot is BLANK_CYCLES + 16·TICK_DIV cycles.
  - Scan order within a frame is digit0, digit1, digit2, digit3, then wrap to digit0.
- FSM has two states:
  - BLANK: SegmentDrivers=4'hF and SevenSegment=8'hFF. Lasts BLANK_CYCLES cycles, then goes to SCAN.
  - SCAN: lasts 16·TICK_DIV cycles. It then goes to BLANK and the digit index increments mod 4.
- Snapshot:
  - On the first cycle of BLANK with index 0, frame_start=1.
  - In that same cycle, digit3..0, dp_mask and brightness are captured into shadow registers.
  - Input changes at any other time take effect only at the next frame_start.
- PWM during SCAN:
  - The sub-tick index s (0..15) advances every TICK_DIV cycles.
  - The selected anode is low while s ≤ shadow brightness and high otherwise.
  - Segments stay driven for the whole SCAN state.
- Segment decode (active-low, dp off), 0–9 = C0, F9, A4, B0, 99, 92, 82, F8, 80, 90.
  - Codes 10–15 decode to FF (blank).
  - When the shadow dp_mask bit for the digit is 1, bit 7 is cleared.
- display_en=0 forces SegmentDrivers=4'hF from the next cycle. FSM, counters and snapshots continue unchanged.

## Timing
- Reset values: SegmentDrivers=4'hF, SevenSegment=8'hFF, frame_start=0.
  - FSM=BLANK, index=0, all counters 0, shadows 0.
- First frame_start occurs on the first clock edge after Reset deasserts.
- All outputs are registered.
  - Outputs for a slot appear 1 cycle after the FSM enters that state.
  - frame_start is asserted in the cycle the snapshot registers load.
- Frame period is 4·(BLANK_CYCLES + 16·TICK_DIV) cycles. With the defaults this is 400 800 cycles (≈249.5 Hz refresh).
- Reset asserted mid-operation: outputs go to their reset values asynchronously, with no wait for a clock edge. The FSM restarts at BLANK, index 0.
- At most one anode is low in any cycle, and never during BLANK. No anode changes without an intervening BLANK state.
- Brightness 15 gives an anode-low duration of exactly 16·TICK_DIV cycles per slot. Brightness b gives (b+1)·TICK_DIV.
- Counter wrap: the sub-tick counter and the slot counter reload exactly at their terminal count. No cycle is skipped or duplicated across the index 3→0 wrap.

## Configuration
- SS_LEADING_BLANK_EN:
  - Defined: if the shadow digit3 == 0, digit3's slot outputs SevenSegment=8'hFF, or 8'h7F if its dp is set. The anode timing is unchanged.
  - Undefined: digit3 = 0 displays C0 like any other digit.

## Test plan
- Reset: assert Reset mid-SCAN with TICK_DIV=4, BLANK_CYCLES=2. The same cycle shows SegmentDrivers=F, SevenSegment=FF. The first frame_start comes 1 cycle after release.
- Full brightness: digits 1,2,3,4 (digit3..0), brightness=15, TICK_DIV=4, BLANK_CYCLES=2.
  - Anodes go low in order E, D, B, 7, for 64 cycles each, with segments 99, B0, A4, F9.
  - 2 blank cycles between slots; frame period 264.
- Minimum brightness: brightness=0. Each anode is low for exactly 4 cycles per slot, starting at the first SCAN cycle.
- Snapshot coherence: change digit0 from 4 to 7 mid-frame. The old value persists until after the next frame_start, then the digit0 slot shows F8.
- Decode edges:
  - digit1=4'hB with dp_mask=4'b0010 gives 7F on the digit1 slot.
  - display_en=0 keeps SegmentDrivers=F while frame_start keeps pulsing every 264 cycles.
- Leading blank: digit3=0 shows FF in the digit3 slot with SS_LEADING_BLANK_EN defined, and C0 without it.

Source files
------------

// File: rtl/ss_scan_controller.sv
// ss_scan_controller: four-digit seven-segment scan controller.
// Drives one digit at a time on the shared cathode bus. Each digit slot is a
// blanking guard followed by a PWM-dimmed scan window. The BCD digits, the
// decimal-point mask and the brightness are snapshotted once per frame.
// Optional feature macro: SS_LEADING_BLANK_EN (blank a leading zero in digit3).
module ss_scan_controller #(
    parameter int unsigned TICK_DIV     = 6250,
    parameter int unsigned BLANK_CYCLES = 200
) (
    input  logic       CLK100MHZ,
    input  logic       Reset,
    input  logic [3:0] digit3,
    input  logic [3:0] digit2,
    input  logic [3:0] digit1,
    input  logic [3:0] digit0,
    input  logic [3:0] dp_mask,
    input  logic [3:0] brightness,
    input  logic       display_en,
    output logic [3:0] SegmentDrivers,
    output logic [7:0] SevenSegment,
    output logic       frame_start
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

    typedef enum logic {
        S_BLANK,
        S_SCAN
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [3:0]      sub_q, sub_d;
    logic [3:0][3:0] dig_q, dig_d;
    logic [3:0]      dp_q, dp_d;
    logic [3:0]      bri_q, bri_d;
    logic [3:0]      an_q, an_d;
    logic [7:0]      seg_q, seg_d;
    logic            fs_q, fs_d;
    logic [3:0]      cur_digit;

    // BCD to active-low cathodes {dp,g,f,e,d,c,b,a}, dp off; 10-15 blank.
    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // State, counters, shadows and registered outputs.
    always_ff @(posedge CLK100MHZ or posedge Reset) begin
        if (Reset) begin
            state_q <= S_BLANK;
            idx_q   <= '0;
            bcnt_q  <= '0;
            tick_q  <= '0;
            sub_q   <= '0;
            dig_q   <= '0;
            dp_q    <= '0;
            bri_q   <= '0;
            an_q    <= '1;
            seg_q   <= '1;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            tick_q  <= tick_d;
            sub_q   <= sub_d;
            dig_q   <= dig_d;
            dp_q    <= dp_d;
            bri_q   <= bri_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            fs_q    <= fs_d;
        end
    end

    // Next-state sequencing, snapshot capture and output decode.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        bcnt_d    = bcnt_q;
        tick_d    = tick_q;
        sub_d     = sub_q;
        dig_d     = dig_q;
        dp_d      = dp_q;
        bri_d     = bri_q;
        an_d      = '1;
        seg_d     = '1;
        fs_d      = 1'b0;
        cur_digit = dig_q[idx_q];

        case (state_q)
            S_BLANK: begin
                // First guard cycle of digit0 is the frame boundary.
                if (bcnt_q == '0 && idx_q == 2'd0) begin
                    fs_d  = 1'b1;
                    dig_d = {digit3, digit2, digit1, digit0};
                    dp_d  = dp_mask;
                    bri_d = brightness;
                end
                if (bcnt_q == BLANK_LAST) begin
                    bcnt_d  = '0;
                    tick_d  = '0;
                    sub_d   = '0;
                    state_d = S_SCAN;
                end else begin
                    bcnt_d = bcnt_q + BW'(1);
                end
            end
            S_SCAN: begin
                seg_d = seg_decode(cur_digit);
`ifdef SS_LEADING_BLANK_EN
                if (idx_q == 2'd3 && cur_digit == 4'd0) begin
                    seg_d = 8'hFF;
                end
`endif
                if (dp_q[idx_q]) begin
                    seg_d[7] = 1'b0;
                end
                if (sub_q <= bri_q) begin
                    an_d[idx_q] = 1'b0;
                end
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (sub_q == 4'd15) begin
                        sub_d   = '0;
                        idx_d   = idx_q + 2'd1;
                        state_d = S_BLANK;
                    end else begin
                        sub_d = sub_q + 4'd1;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: state_d = S_BLANK;
        endcase

        if (!display_en) begin
            an_d = '1;
        end
    end

    assign SegmentDrivers = an_q;
    assign SevenSegment   = seg_q;
    assign frame_start    = fs_q;

endmodule

// File: tb/tb_ss_scan_controller.sv
// Directed testbench for ss_scan_controller with TICK_DIV=4, BLANK_CYCLES=2
// (slot = 66 cycles, frame = 264 cycles).
module tb_ss_scan_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] digit3, digit2, digit1, digit0;
    logic [3:0] dp_mask, brightness;
    logic       display_en;
    logic [3:0] an;
    logic [7:0] seg;
    logic       fs;

    int errors = 0;
    int checks = 0;

    logic [3:0] an_tr  [0:264];
    logic [7:0] seg_tr [0:264];
    logic       fs_tr  [0:264];
    bit         cap_to;

    ss_scan_controller #(.TICK_DIV(4), .BLANK_CYCLES(2)) dut (
        .CLK100MHZ     (clk),
        .Reset         (rst),
        .digit3        (digit3),
        .digit2        (digit2),
        .digit1        (digit1),
        .digit0        (digit0),
        .dp_mask       (dp_mask),
        .brightness    (brightness),
        .display_en    (display_en),
        .SegmentDrivers(an),
        .SevenSegment  (seg),
        .frame_start   (fs)
    );

    always #5 clk = ~clk;

    // Waits for frame_start (bounded) and records 265 samples from that cycle;
    // optionally changes digit0 at sample chg_t.
    task automatic capture_frame(input int chg_t, input logic [3:0] chg_val);
        int n;
        n = 0;
        cap_to = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (fs !== 1'b1 && n < 600);
        if (fs !== 1'b1) cap_to = 1'b1;
        for (int t = 0; t <= 264; t++) begin
            if (t > 0) @(negedge clk);
            an_tr[t]  = an;
            seg_tr[t] = seg;
            fs_tr[t]  = fs;
            if (t == chg_t) digit0 = chg_val;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        digit3 = 4'd1; digit2 = 4'd2; digit1 = 4'd3; digit0 = 4'd4;
        dp_mask = 4'b0000; brightness = 4'd15; display_en = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (an !== 4'hF || seg !== 8'hFF || fs !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got an=%h seg=%h fs=%b, want an=F seg=FF fs=0", an, seg, fs);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (fs !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_fs: got fs=%b, want 1", fs);
        end
    endtask

    task automatic test_full_brightness();
        logic [3:0] ea [4];
        logic [7:0] es [4];
        logic [3:0] xa;
        logic [7:0] xs;
        int pos, slot;
        ea = '{4'hE, 4'hD, 4'hB, 4'h7};
        es = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        digit3 = 4'd1; digit2 = 4'd2; digit1 = 4'd3; digit0 = 4'd4; brightness = 4'd15;
        capture_frame(-1, 4'd0);
        checks++;
        if (cap_to) begin errors++; $display("FAIL full_fs_timeout: no frame_start within 600 cycles"); end
        for (int t = 0; t <= 264; t++) begin
            pos = t % 66; slot = (t / 66) % 4;
            xa = (pos >= 2) ? ea[slot] : 4'hF;
            xs = (pos >= 2) ? es[slot] : 8'hFF;
            checks++;
            if (an_tr[t] !== xa || seg_tr[t] !== xs || fs_tr[t] !== (t == 0 || t == 264)) begin
                errors++;
                $display("FAIL full t=%0d: got an=%h seg=%h fs=%b, want an=%h seg=%h fs=%b",
                         t, an_tr[t], seg_tr[t], fs_tr[t], xa, xs, (t == 0 || t == 264));
            end
        end
    endtask

    task automatic test_brightness_levels();
        logic [3:0] ea [4];
        logic [3:0] lv [2];
        logic [3:0] xa;
        int pos, slot, low;
        ea = '{4'hE, 4'hD, 4'hB, 4'h7};
        lv = '{4'd0, 4'd5};
        for (int k = 0; k < 2; k++) begin
            brightness = lv[k];
            low = (int'(lv[k]) + 1) * 4;
            capture_frame(-1, 4'd0);
            checks++;
            if (cap_to) begin errors++; $display("FAIL bright_fs_timeout: level %0d", lv[k]); end
            for (int t = 0; t < 264; t++) begin
                pos = t % 66; slot = t / 66;
                xa = (pos >= 2 && pos < 2 + low) ? ea[slot] : 4'hF;
                checks++;
                if (an_tr[t] !== xa) begin
                    errors++;
                    $display("FAIL bright%0d t=%0d: got an=%h, want %h", lv[k], t, an_tr[t], xa);
                end
            end
        end
        brightness = 4'd15;
    endtask

    task automatic test_snapshot();
        int pos;
        capture_frame(30, 4'd7);
        checks++;
        if (cap_to) begin errors++; $display("FAIL snap_fs_timeout: first frame"); end
        for (int t = 2; t < 66; t++) begin
            checks++;
            if (seg_tr[t] !== 8'h99) begin
                errors++;
                $display("FAIL snap_old t=%0d: got seg=%h, want 99", t, seg_tr[t]);
            end
        end
        capture_frame(-1, 4'd0);
        checks++;
        if (cap_to) begin errors++; $display("FAIL snap_fs_timeout: second frame"); end
        for (int t = 0; t < 66; t++) begin
            checks++;
            if (seg_tr[t] !== ((t >= 2) ? 8'hF8 : 8'hFF)) begin
                errors++;
                $display("FAIL snap_new t=%0d: got seg=%h, want %h", t, seg_tr[t], (t >= 2) ? 8'hF8 : 8'hFF);
            end
        end
    endtask

    task automatic test_decode_edges();
        logic [7:0] es [4];
        logic [7:0] xs;
        int pos, slot;
        digit3 = 4'd6; digit2 = 4'd5; digit1 = 4'hB; digit0 = 4'd8; dp_mask = 4'b0011;
        es = '{8'h00, 8'h7F, 8'h92, 8'h82};
        capture_frame(-1, 4'd0);
        checks++;
        if (cap_to) begin errors++; $display("FAIL decode_fs_timeout"); end
        for (int t = 0; t < 264; t++) begin
            pos = t % 66; slot = t / 66;
            xs = (pos >= 2) ? es[slot] : 8'hFF;
            checks++;
            if (seg_tr[t] !== xs) begin
                errors++;
                $display("FAIL decode t=%0d: got seg=%h, want %h", t, seg_tr[t], xs);
            end
        end
        dp_mask = 4'b0000;
    endtask

    task automatic test_display_en();
        logic [7:0] es [4];
        logic [7:0] xs;
        int pos, slot;
        digit3 = 4'd1; digit2 = 4'd2; digit1 = 4'd3; digit0 = 4'd4;
        es = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        display_en = 1'b0;
        capture_frame(-1, 4'd0);
        checks++;
        if (cap_to) begin errors++; $display("FAIL dis_fs_timeout"); end
        for (int t = 0; t <= 264; t++) begin
            pos = t % 66; slot = (t / 66) % 4;
            xs = (pos >= 2) ? es[slot] : 8'hFF;
            checks++;
            if (an_tr[t] !== 4'hF || seg_tr[t] !== xs || fs_tr[t] !== (t == 0 || t == 264)) begin
                errors++;
                $display("FAIL display_en t=%0d: got an=%h seg=%h fs=%b, want an=F seg=%h fs=%b",
                         t, an_tr[t], seg_tr[t], fs_tr[t], xs, (t == 0 || t == 264));
            end
        end
        display_en = 1'b1;
    endtask

    task automatic test_leading_blank();
        logic [7:0] es [4];
        logic [7:0] xs;
        int pos, slot;
        digit3 = 4'd0; digit2 = 4'd7; digit1 = 4'd0; digit0 = 4'd9; dp_mask = 4'b1000;
`ifdef SS_LEADING_BLANK_EN
        es = '{8'h90, 8'hC0, 8'hF8, 8'h7F};
`else
        es = '{8'h90, 8'hC0, 8'hF8, 8'h40};
`endif
        capture_frame(-1, 4'd0);
        checks++;
        if (cap_to) begin errors++; $display("FAIL lead_fs_timeout"); end
        for (int t = 0; t < 264; t++) begin
            pos = t % 66; slot = t / 66;
            xs = (pos >= 2) ? es[slot] : 8'hFF;
            checks++;
            if (seg_tr[t] !== xs) begin
                errors++;
                $display("FAIL leading t=%0d: got seg=%h, want %h", t, seg_tr[t], xs);
            end
        end
        dp_mask = 4'b0000;
    endtask

    task automatic test_reset_mid();
        int n;
        digit3 = 4'd1; digit2 = 4'd2; digit1 = 4'd3; digit0 = 4'd4; brightness = 4'd15;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fs !== 1'b1 && n < 600);
        checks++;
        if (fs !== 1'b1) begin errors++; $display("FAIL rmid_fs_timeout"); end
        repeat (9) @(negedge clk);
        checks++;
        if (an !== 4'hE) begin errors++; $display("FAIL rmid_pre: got an=%h, want E", an); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (an !== 4'hF || seg !== 8'hFF || fs !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async: got an=%h seg=%h fs=%b, want F FF 0", an, seg, fs);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (fs !== 1'b1) begin errors++; $display("FAIL rmid_fs1: got fs=%b, want 1", fs); end
        @(negedge clk);
        checks++;
        if (fs !== 1'b0 || an !== 4'hF) begin
            errors++;
            $display("FAIL rmid_fs2: got fs=%b an=%h, want 0 F", fs, an);
        end
        @(negedge clk);
        checks++;
        if (an !== 4'hE || seg !== 8'h99) begin
            errors++;
            $display("FAIL rmid_scan: got an=%h seg=%h, want E 99", an, seg);
        end
    endtask

    initial begin
        test_reset();
        test_full_brightness();
        test_brightness_levels();
        test_snapshot();
        test_decode_edges();
        test_display_en();
        test_leading_blank();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
